serial_add_ctrl: RTL and testbench

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_ctrl_if.sv | 25 ++
 rtl/serial_add_ctrl.sv | 119 +++++++++++
 tb/tb_serial_add_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/serial_add_ctrl_if.sv
// Operand/result bundle for serial_add_ctrl: the requester drives operands and
// start, the adder returns status and the result word.
interface serial_add_ctrl_if #(
  parameter int NIBBLES = 4
);
  logic                   start;
  logic                   sub;
  logic [4*NIBBLES-1:0]   a;
  logic [4*NIBBLES-1:0]   b;
  logic                   busy;
  logic                   done;
  logic [4*NIBBLES-1:0]   sum;
  logic                   c_out;
  logic                   overflow;

  modport master (
    output start, sub, a, b,
    input  busy, done, sum, c_out, overflow
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, sum, c_out, overflow
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Nibble-serial add/subtract: one 4-bit ripple slice is reused LSB nibble first,
// taking NIBBLES cycles in RUN followed by a single DONE cycle.
//
// state | meaning
// IDLE  | waiting for start; results from the last operation are held
// RUN   | one nibble per edge, index idx_q
// DONE  | one-cycle done pulse, then back to IDLE
module serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic              clock,
  input  logic              reset,
  serial_add_ctrl_if.slave  bus
);
  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             sub_q, sub_d, carry_q, carry_d;
  logic             c_out_q, c_out_d, ovf_q, ovf_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [3:0]       op_a, op_b, slice_s;
  logic [4:0]       c;
  logic             last;

  // Shared full-adder slice; c[3] is the carry into the slice MSB for overflow.
  always_comb begin
    op_a = a_q[{idx_q, 2'b00} +: 4];
    op_b = b_q[{idx_q, 2'b00} +: 4] ^ {4{sub_q}};
    slice_s = 4'h0;
    c = 5'h0;
    c[0] = carry_q;
    for (int i = 0; i < 4; i++) begin
      slice_s[i] = op_a[i] ^ op_b[i] ^ c[i];
      c[i+1]     = (op_a[i] & op_b[i]) | (op_a[i] & c[i]) | (op_b[i] & c[i]);
    end
  end

  assign last = (idx_q == IDX_W'(NIBBLES - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          sub_d   = bus.sub;
          carry_d = bus.sub;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[{idx_q, 2'b00} +: 4] = slice_s;
        carry_d = c[4];
        if (last) begin
          idx_d   = '0;
          c_out_d = c[4];
          ovf_d   = c[4] ^ c[3];
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.sum      = sum_q;
  assign bus.c_out    = c_out_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_serial_add_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;

  typedef struct packed {
    logic [15:0] sum;
    logic        c;
    logic        o;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   fails  = 0;

  serial_add_ctrl_if #(.NIBBLES(4)) bus ();

  serial_add_ctrl #(.NIBBLES(4)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_done got=done exp=no_done sum=%0h", bus.sum);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("result_sum", 32'(bus.sum), 32'(e.sum));
        check("result_c_out", 32'(bus.c_out), 32'(e.c));
        check("result_overflow", 32'(bus.overflow), 32'(e.o));
      end
    end
  end

  task automatic do_op(input logic [15:0] av, input logic [15:0] bv, input logic s,
                       input logic [15:0] es, input logic ec, input logic eo);
    exp_t e;
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      if (!bus.busy && !bus.done) break;
      @(negedge clk);
    end
    bus.start = 1'b1;
    bus.a = av;
    bus.b = bv;
    bus.sub = s;
    e.sum = es;
    e.c = ec;
    e.o = eo;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a = ~av;
    bus.b = bv ^ 16'h5A5A;
    bus.sub = ~s;
    check("busy_after_accept", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("busy_during_run", {30'd0, bus.busy, bus.done}, 32'b10);
    end
    @(posedge clk);
    #1;
    check("done_latency", {30'd0, bus.busy, bus.done}, 32'b01);
    @(posedge clk);
    #1;
    check("done_one_cycle", {30'd0, bus.busy, bus.done}, 32'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int done_cnt;
    int done_at[2];
    bus.start = 1'b0;
    bus.sub = 1'b0;
    bus.a = 16'h0;
    bus.b = 16'h0;
    #2 rst = 1'b1;
    #2;
    check("reset_outputs", {13'd0, bus.busy, bus.done, bus.c_out, bus.overflow, bus.sum}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    do_op(16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    do_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      bus.a = 16'($urandom);
      bus.b = 16'($urandom);
      check("hold_result", {15'd0, bus.c_out, bus.overflow, bus.sum}, {15'd0, 1'b1, 1'b1, 16'h7FFF});
      check("hold_idle_flags", {30'd0, bus.busy, bus.done}, 32'b00);
    end

    // start held for 12 edges: two operations, operands swapped only while not capturing
    sb_q.push_back('{sum: 16'h3333, c: 1'b0, o: 1'b0});
    sb_q.push_back('{sum: 16'h0300, c: 1'b1, o: 1'b0});
    done_cnt = 0;
    done_at[0] = -1;
    done_at[1] = -1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 16'h1111;
    bus.b = 16'h2222;
    bus.sub = 1'b0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        if (done_cnt < 2) done_at[done_cnt] = cyc;
        done_cnt++;
      end
      if (cyc == 1 || cyc == 7) begin
        bus.a = 16'hFFFF;
        bus.b = 16'hFFFF;
        bus.sub = 1'b1;
      end
      if (cyc == 4) begin
        bus.a = 16'hF100;
        bus.b = 16'h1200;
        bus.sub = 1'b0;
      end
    end
    bus.start = 1'b0;
    check("held_start_done_count", 32'(done_cnt), 32'd2);
    check("held_start_first_done", 32'(done_at[0]), 32'd4);
    check("held_start_second_done", 32'(done_at[1]), 32'd10);

    // abort mid-RUN: nothing pushed, so any done pulse is flagged by the monitor
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 16'h1234;
    bus.b = 16'h0FCD;
    bus.sub = 1'b0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_outputs", {13'd0, bus.busy, bus.done, bus.c_out, bus.overflow, bus.sum}, 32'd0);
    #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check("abort_no_done", {30'd0, bus.busy, bus.done}, 32'b00);
    end
    do_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
